wb_stream_reader_dma: RTL and testbench

//  Datapath stage of the stream reader, downstream of the stream reader config registers.
//  On an enable pulse it reads a memory buffer as a Wishbone B3 master, using incrementing bursts.
//  The fetched words are buffered in an internal FIFO and emitted on a valid/ready stream.
//  It reports busy and tx_cnt back to the config registers, which raise irq on busy falling.

---
 rtl/wb_stream_reader_dma.sv | 192 +++++++++++++++++++
 tb/tb_wb_stream_reader_dma.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_reader_dma.sv
// wb_stream_reader_dma
//   Reads a memory buffer as a Wishbone B3 master using incrementing bursts and
//   replays the fetched words on a valid/ready stream through a FWFT FIFO.
//   Reports busy and tx_cnt (words acked in the current transfer) upstream.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbm_*                        Wishbone B3 read master (byte address, cti bursts)
//   enable                       single-cycle start pulse, honoured only when idle
//   start_adr/buf_size/burst_size  transfer base (bytes), length (bytes), burst (words)
//   busy, tx_cnt                 status back to the config registers
//   stream_data_o/valid_o/ready_i  output stream
//
// State        | meaning
// S_IDLE       | no transfer; waiting for enable
// S_WAIT       | transfer active; waiting for FIFO room for the next burst
// S_BURST      | cyc/stb asserted; collecting beats until the last ack or an error
module wb_stream_reader_dma #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 6
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  output logic [WB_AW-1:0]   wbm_adr_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic [WB_DW-1:0]   tx_cnt,
  output logic [WB_DW-1:0]   stream_data_o,
  output logic               stream_valid_o,
  input  logic               stream_ready_i
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t             state_q, state_d;
  logic [WB_AW-1:0]   adr_q;
  logic [WB_AW-1:0]   words_q;
  logic [CW-1:0]      blen_q;
  logic [CW-1:0]      beats_q;
  logic [WB_DW-1:0]   tx_cnt_q;

  logic [WB_DW-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;

  logic               start_ok;
  logic               space_ok;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic [CW-1:0]      beats_nxt;
  logic [CW-1:0]      blen_clamp;
  logic               unused_buf_lsb;

  assign unused_buf_lsb = ^buf_size[1:0];

  assign start_ok  = enable && (state_q == S_IDLE) && (buf_size[WB_AW-1:2] != '0);
  assign last_beat = (beats_q == CW'(1));
  assign push      = (state_q == S_BURST) && wbm_ack_i && !wbm_err_i;
  assign pop       = (count_q != '0) && stream_ready_i;

  always_comb begin
    blen_clamp = burst_size[CW-1:0];
    if (burst_size == '0)
      blen_clamp = CW'(1);
    else if (burst_size > WB_AW'(DEPTH))
      blen_clamp = CW'(DEPTH);
  end

  // Shorten the final burst to what is left; words_q < blen_q guarantees the
  // truncation below is lossless.
  always_comb begin
    beats_nxt = blen_q;
    if (words_q < WB_AW'(blen_q))
      beats_nxt = words_q[CW-1:0];
  end

  // Room is reserved for the whole burst up front, so pushes can never overflow.
  assign space_ok = ({1'b0, count_q} + {1'b0, beats_nxt}) <= (CW+1)'(DEPTH);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_cti_o = 3'b000;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (space_ok)
          state_d = S_BURST;
      end
      S_BURST: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_cti_o = last_beat ? 3'b111 : 3'b010;
        if (wbm_err_i)
          state_d = S_IDLE;
        else if (wbm_ack_i && last_beat)
          state_d = (words_q == WB_AW'(1)) ? S_IDLE : S_WAIT;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      adr_q    <= '0;
      words_q  <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (enable && (state_q == S_IDLE)) begin
        adr_q    <= start_adr;
        words_q  <= {2'b00, buf_size[WB_AW-1:2]};
        blen_q   <= blen_clamp;
        tx_cnt_q <= '0;
      end
      if ((state_q == S_WAIT) && space_ok)
        beats_q <= beats_nxt;
      if (push) begin
        adr_q    <= adr_q + WB_AW'(4);
        words_q  <= words_q - WB_AW'(1);
        beats_q  <= beats_q - CW'(1);
        tx_cnt_q <= tx_cnt_q + WB_DW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem[wr_ptr_q] <= wbm_dat_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign wbm_adr_o      = adr_q;
  assign wbm_sel_o      = '1;
  assign wbm_we_o       = 1'b0;
  assign wbm_bte_o      = 2'b00;
  assign tx_cnt         = tx_cnt_q;
  assign stream_data_o  = mem[rd_ptr_q];
  assign stream_valid_o = (count_q != '0);

endmodule

// File: tb/tb_wb_stream_reader_dma.sv
module tb_wb_stream_reader_dma;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm_adr, wbm_dat;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;
  logic        enable;
  logic [31:0] start_adr, buf_size, burst_size;
  logic        busy;
  logic [31:0] tx_cnt, sdata;
  logic        svalid, sready;

  always #5 clk = ~clk;

  wb_stream_reader_dma #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbm_adr_o(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .tx_cnt(tx_cnt),
    .stream_data_o(sdata), .stream_valid_o(svalid), .stream_ready_i(sready)
  );

  int checks = 0;
  int errors = 0;

  bit [31:0] exp_adr[$];
  bit [2:0]  exp_cti[$];
  bit [31:0] obs_adr[$];
  bit [2:0]  obs_cti[$];
  bit [31:0] obs_stream[$];

  int        err_idx = -1;
  int        ready_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int        busy_falls = 0;
  bit        busy_prev = 1'b0;
  bit        prev_wait = 1'b0, prev_final = 1'b0, prev_hold = 1'b0;
  bit [31:0] prev_adr, prev_sdata;
  bit [2:0]  prev_cti;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave, stream sink and protocol monitor. Everything is decided on the
  // falling edge, so the values seen here are those the DUT samples next.
  always @(negedge clk) begin
    if (!rst_n) begin
      wbm_ack = 1'b0; wbm_err = 1'b0;
      prev_wait = 1'b0; prev_final = 1'b0; prev_hold = 1'b0; busy_prev = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("stb_hold", {31'd0, wbm_stb}, 32'd1);
        chk("adr_hold", wbm_adr, prev_adr);
        chk("cti_hold", {29'd0, wbm_cti}, {29'd0, prev_cti});
      end
      if (prev_final) chk("cyc_gap", {31'd0, wbm_cyc}, 32'd0);
      if (prev_hold)  chk("data_hold", sdata, prev_sdata);
      if (busy_prev && !busy) busy_falls++;
      busy_prev = busy;

      if (wbm_cyc && wbm_stb) begin
        wbm_dat = mem_fn(wbm_adr);
        if (obs_adr.size() == err_idx) begin
          wbm_ack = 1'b0;
          wbm_err = ($urandom_range(0, 1) == 1);
        end else begin
          wbm_err = 1'b0;
          wbm_ack = ($urandom_range(0, 3) != 0);
        end
      end else begin
        wbm_ack = 1'b0; wbm_err = 1'b0;
        wbm_dat = $urandom;
      end
      prev_wait  = wbm_cyc && wbm_stb && !wbm_ack && !wbm_err;
      prev_adr   = wbm_adr;
      prev_cti   = wbm_cti;
      prev_final = 1'b0;
      if (wbm_cyc && wbm_stb && wbm_ack && !wbm_err) begin
        obs_adr.push_back(wbm_adr);
        obs_cti.push_back(wbm_cti);
        prev_final = (wbm_cti == 3'b111);
      end

      sready = (ready_mode == 0) ? 1'b0 :
               (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      prev_hold  = svalid && !sready;
      prev_sdata = sdata;
      if (svalid && sready) obs_stream.push_back(sdata);
    end
  end

  // Expected beat sequence from the transfer rules: bursts of
  // min(clamped burst, words left), cti 111 on each burst's last beat.
  task automatic build_model(input logic [31:0] start, input logic [31:0] size,
                             input logic [31:0] burst, input int eidx);
    int words;
    int blen;
    int k;
    int beats;
    words = int'(size >> 2);
    blen  = (burst == 0) ? 1 : (burst > DEPTH) ? DEPTH : int'(burst);
    k = 0;
    exp_adr.delete();
    exp_cti.delete();
    while (k < words) begin
      beats = (words - k < blen) ? (words - k) : blen;
      for (int i = 0; i < beats; i++) begin
        if (eidx < 0 || k < eidx) begin
          exp_adr.push_back(start + 32'(4 * k));
          exp_cti.push_back((i == beats - 1) ? 3'b111 : 3'b010);
        end
        k++;
      end
    end
  endtask

  task automatic start_xfer(input logic [31:0] start, input logic [31:0] size,
                            input logic [31:0] burst, input int eidx);
    @(negedge clk);
    obs_adr.delete(); obs_cti.delete(); obs_stream.delete();
    busy_falls = 0;
    err_idx = eidx;
    build_model(start, size, burst, eidx);
    start_adr = start; buf_size = size; burst_size = burst;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", {31'd0, n < bound}, 32'd1);
    n = 0;
    while (obs_stream.size() < exp_adr.size() && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, n < bound}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_result();
    int n;
    chk("tx_cnt", tx_cnt, 32'(exp_adr.size()));
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("busy_falls", 32'(busy_falls), 32'd1);
    chk("beat_count", 32'(obs_adr.size()), 32'(exp_adr.size()));
    chk("stream_count", 32'(obs_stream.size()), 32'(exp_adr.size()));
    n = (obs_adr.size() < exp_adr.size()) ? obs_adr.size() : exp_adr.size();
    for (int i = 0; i < n; i++) begin
      chk("beat_adr", obs_adr[i], exp_adr[i]);
      chk("beat_cti", {29'd0, obs_cti[i]}, {29'd0, exp_cti[i]});
    end
    n = (obs_stream.size() < exp_adr.size()) ? obs_stream.size() : exp_adr.size();
    for (int i = 0; i < n; i++)
      chk("stream_data", obs_stream[i], mem_fn(exp_adr[i]));
  endtask

  initial begin
    int n;
    enable = 1'b0; start_adr = '0; buf_size = '0; burst_size = '0;
    wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat = '0; sready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'd0, wbm_cyc}, 32'd0);
    chk("rst_stb", {31'd0, wbm_stb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cti", {29'd0, wbm_cti}, 32'd0);
    chk("rst_adr", wbm_adr, 32'd0);
    chk("rst_tx_cnt", tx_cnt, 32'd0);
    chk("rst_valid", {31'd0, svalid}, 32'd0);
    chk("sel_const", {28'd0, wbm_sel}, 32'hF);
    chk("we_const", {31'd0, wbm_we}, 32'd0);
    chk("bte_const", {30'd0, wbm_bte}, 32'd0);
    rst_n = 1'b1;

    // Two 4-beat bursts, sink always ready.
    ready_mode = 1;
    start_xfer(32'h1000, 32'd32, 32'd4, -1);
    wait_done(2000);
    check_result();

    // Zero-word buffer: busy never asserts, tx_cnt cleared.
    start_xfer(32'h2000, 32'd3, 32'd4, -1);
    repeat (5) begin
      chk("zero_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("zero_tx_cnt", tx_cnt, 32'd0);
    chk("zero_cyc", {31'd0, wbm_cyc}, 32'd0);

    // Bursts 4,4,2 with a random sink; an enable mid-transfer must be ignored.
    ready_mode = 2;
    start_xfer(32'h3000, 32'd40, 32'd4, -1);
    repeat (4) @(negedge clk);
    start_adr = 32'h9000; buf_size = 32'd400; burst_size = 32'd2;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(2000);
    check_result();

    // Burst 0 behaves as 1; burst 1000 clamps to the FIFO depth.
    start_xfer(32'h4000, 32'd12, 32'd0, -1);
    wait_done(2000);
    check_result();
    start_xfer(32'h5000, 32'd80, 32'd1000, -1);
    wait_done(2000);
    check_result();

    // Sink stalled: exactly a FIFO's worth is fetched, then the FSM parks.
    ready_mode = 0;
    start_xfer(32'h6000, 32'd256, 32'd4, -1);
    repeat (300) @(negedge clk);
    chk("stall_beats", 32'(obs_adr.size()), 32'(DEPTH));
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_cyc", {31'd0, wbm_cyc}, 32'd0);
    chk("stall_valid", {31'd0, svalid}, 32'd1);
    ready_mode = 2;
    wait_done(4000);
    check_result();

    // Address wraps past the top of the address space.
    start_xfer(32'hFFFF_FFF8, 32'd16, 32'd4, -1);
    wait_done(2000);
    check_result();

    // Error on beat 3 of burst 2: six words acked and streamed, no restart.
    start_xfer(32'h7000, 32'd64, 32'd4, 6);
    wait_done(2000);
    check_result();
    repeat (10) @(negedge clk);
    chk("err_cyc_after", {31'd0, wbm_cyc}, 32'd0);
    chk("err_tx_cnt", tx_cnt, 32'd6);
    err_idx = -1;

    // Reset mid-burst, then a clean fresh transfer.
    start_xfer(32'h8000, 32'd256, 32'd8, -1);
    n = 0;
    while (!(obs_adr.size() >= 3 && wbm_cyc) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midburst_timeout", {31'd0, n < 2000}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cyc", {31'd0, wbm_cyc}, 32'd0);
    chk("mrst_stb", {31'd0, wbm_stb}, 32'd0);
    chk("mrst_valid", {31'd0, svalid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_tx_cnt", tx_cnt, 32'd0);
    repeat (2) @(negedge clk);
    obs_adr.delete(); obs_cti.delete(); obs_stream.delete();
    rst_n = 1'b1;
    start_xfer(32'h1000, 32'd32, 32'd4, -1);
    wait_done(2000);
    check_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
